// File: rtl/timer_pkg.sv
// Shared timer definitions: register map, TCR/TSR bit positions and prescaler
// rate encodings, used by the control block and the counter bench.
package timer_pkg;

  localparam logic [7:0] ADDR_TDR_DEF = 8'h00;
  localparam logic [7:0] ADDR_TCR_DEF = 8'h01;
  localparam logic [7:0] ADDR_TSR_DEF = 8'h02;

  localparam int TCR_LOAD_BIT = 7;
  localparam int TCR_UPDN_BIT = 5;
  localparam int TCR_EN_BIT   = 4;

  localparam int TSR_OVF_BIT = 0;
  localparam int TSR_UNF_BIT = 1;

  // Tick period is 2^(cks+1) clocks.
  typedef enum logic [1:0] {
    CKS_DIV2  = 2'd0,
    CKS_DIV4  = 2'd1,
    CKS_DIV8  = 2'd2,
    CKS_DIV16 = 2'd3
  } cks_e;

  // TCR readback: load always reads 0, reserved bits read 0.
  function automatic logic [7:0] tcr_readback(input logic up_down, input logic enable,
                                              input cks_e cks);
    logic [7:0] r;
    r               = 8'h00;
    r[TCR_UPDN_BIT] = up_down;
    r[TCR_EN_BIT]   = enable;
    r[1:0]          = cks;
    return r;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Free-running 4-bit divider with a registered history copy; emits a
// registered one-clock tick on each rising edge of the selected divider bit.
module timer_prescaler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] cks,
  output logic       clk_ena
);

  logic [3:0] div_q;
  logic [3:0] div_d;
  logic [3:0] hist_q;
  logic       clk_ena_q;
  logic       clk_ena_d;
  logic       rise;

  // Current and history bits are indexed by the same cks, so a rate switch
  // only ever sees a genuine edge of the newly selected bit.
  always_comb begin
    div_d     = div_q + 4'd1;
    rise      = div_q[cks] & ~hist_q[cks];
    clk_ena_d = enable & rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= 4'd0;
      hist_q    <= 4'd0;
      clk_ena_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      hist_q    <= div_q;
      clk_ena_q <= clk_ena_d;
    end
  end

  assign clk_ena = clk_ena_q;

endmodule

// File: rtl/timer_ctrl.sv
// APB register front-end for the timer counter: TDR load value, TCR control,
// TSR sticky-flag status/clear, plus the prescaler that generates count ticks.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter logic [7:0] ADDR_TDR = ADDR_TDR_DEF,
  parameter logic [7:0] ADDR_TCR = ADDR_TCR_DEF,
  parameter logic [7:0] ADDR_TSR = ADDR_TSR_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  input  logic       overflow,
  input  logic       underflow,
  output logic [7:0] start_counter,
  output logic       load,
  output logic       up_down,
  output logic       enable,
  output logic       clr_overflow,
  output logic       clr_underflow,
  output logic       clk_ena
);

  // Handshake: pready is constantly 1, so every transfer completes in the one
  // cycle where psel & penable are both high; write state commits at the end
  // of that cycle, read data and pslverr are valid combinationally within it.
  logic access, hit_tdr, hit_tcr, hit_tsr, mapped;
  logic wr_tdr, wr_tcr, wr_tsr;

  logic [7:0] tdr_q, tdr_d;
  logic       up_down_q, up_down_d;
  logic       enable_q, enable_d;
  cks_e       cks_q, cks_d;
  logic       load_q, load_d;
  logic       clr_ovf_q, clr_ovf_d;
  logic       clr_unf_q, clr_unf_d;

  always_comb begin
    access  = psel & penable & rst_n;
    hit_tdr = (paddr == ADDR_TDR);
    hit_tcr = (paddr == ADDR_TCR);
    hit_tsr = (paddr == ADDR_TSR);
    mapped  = hit_tdr | hit_tcr | hit_tsr;
    wr_tdr  = access & pwrite & hit_tdr;
    wr_tcr  = access & pwrite & hit_tcr;
    wr_tsr  = access & pwrite & hit_tsr;
  end

  always_comb begin
    tdr_d     = tdr_q;
    up_down_d = up_down_q;
    enable_d  = enable_q;
    cks_d     = cks_q;
    load_d    = 1'b0;
    clr_ovf_d = 1'b0;
    clr_unf_d = 1'b0;
    if (wr_tdr) begin
      tdr_d = pwdata;
    end
    if (wr_tcr) begin
      up_down_d = pwdata[TCR_UPDN_BIT];
      enable_d  = pwdata[TCR_EN_BIT];
      cks_d     = cks_e'(pwdata[1:0]);
      load_d    = pwdata[TCR_LOAD_BIT];
    end
    if (wr_tsr) begin
      clr_ovf_d = pwdata[TSR_OVF_BIT];
      clr_unf_d = pwdata[TSR_UNF_BIT];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdr_q     <= 8'h00;
      up_down_q <= 1'b0;
      enable_q  <= 1'b0;
      cks_q     <= CKS_DIV2;
      load_q    <= 1'b0;
      clr_ovf_q <= 1'b0;
      clr_unf_q <= 1'b0;
    end else begin
      tdr_q     <= tdr_d;
      up_down_q <= up_down_d;
      enable_q  <= enable_d;
      cks_q     <= cks_d;
      load_q    <= load_d;
      clr_ovf_q <= clr_ovf_d;
      clr_unf_q <= clr_unf_d;
    end
  end

  always_comb begin
    prdata = 8'h00;
    if (access && !pwrite) begin
      if (hit_tdr)      prdata = tdr_q;
      else if (hit_tcr) prdata = tcr_readback(up_down_q, enable_q, cks_q);
      else if (hit_tsr) prdata = {6'b0, underflow, overflow};
      else              prdata = 8'h00;
    end
  end

  assign pready        = 1'b1;
  assign pslverr       = access & ~mapped;
  assign start_counter = tdr_q;
  assign load          = load_q;
  assign up_down       = up_down_q;
  assign enable        = enable_q;
  assign clr_overflow  = clr_ovf_q;
  assign clr_underflow = clr_unf_q;

  // The prescaler sees next-state enable/cks so its registered tick already
  // reflects a TCR write in the first cycle after the write commits.
  timer_prescaler u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable_d),
    .cks     (cks_d),
    .clk_ena (clk_ena)
  );

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: register table plus multi-cycle sequences for
// load/tick timing, rate and direction changes, status clears and resets.
module tb_timer_ctrl;
  import timer_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic [7:0] prdata;
  logic       pready, pslverr;
  logic       overflow, underflow;
  logic [7:0] start_counter;
  logic       load, up_down, enable;
  logic       clr_overflow, clr_underflow, clk_ena;

  int n_cmp;
  int n_fail;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic       ovf;
    logic       unf;
    logic       err;
  } vec_t;

  vec_t vecs[17];

  timer_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .psel          (psel),
    .penable       (penable),
    .pwrite        (pwrite),
    .paddr         (paddr),
    .pwdata        (pwdata),
    .prdata        (prdata),
    .pready        (pready),
    .pslverr       (pslverr),
    .overflow      (overflow),
    .underflow     (underflow),
    .start_counter (start_counter),
    .load          (load),
    .up_down       (up_down),
    .enable        (enable),
    .clr_overflow  (clr_overflow),
    .clr_underflow (clr_underflow),
    .clk_ena       (clk_ena)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks: entered and left at posedge+1.
  task automatic apb_write(input logic [7:0] a, input logic [7:0] d, input logic exp_err);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    #3;
    check($sformatf("wr_err@%0h", a), int'(pslverr), int'(exp_err));
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, input logic exp_err);
    logic [7:0] exp;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    #3;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    check($sformatf("rdata@%0h", a), int'(prdata), int'(exp));
    check($sformatf("rd_err@%0h", a), int'(pslverr), int'(exp_err));
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic watch(input int n, output int loads, output int ticks, output int clro,
                       output int clru, output int first, output int min_gap,
                       output int max_gap);
    int last;
    loads = 0; ticks = 0; clro = 0; clru = 0;
    first = -1; min_gap = 1000; max_gap = 0; last = -1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (load) loads++;
      if (clr_overflow) clro++;
      if (clr_underflow) clru++;
      if (clk_ena) begin
        ticks++;
        if (first < 0) first = i;
        if (last >= 0) begin
          if (i - last < min_gap) min_gap = i - last;
          if (i - last > max_gap) max_gap = i - last;
        end
        last = i;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_tick(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (clk_ena) seen = 1'b1;
    end
    check("tick_wait_timeout", int'(seen), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int loads, ticks, clro, clru, first, min_gap, max_gap;
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h00; pwdata = 8'h00; overflow = 1'b0; underflow = 1'b0;

    vecs[0]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 8'h01, 8'h6E, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h01, 8'h22, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h02, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'h02, 8'h03, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 8'h02, 8'h02, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 8'h07, 8'hFF, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 8'h07, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 8'h01, 8'h22, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1};

    // Reset held 5 clk, with an unmapped access attempted during reset
    repeat (5) @(posedge clk);
    #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h07;
    #2;
    check("rst_start_counter", int'(start_counter), 0);
    check("rst_load", int'(load), 0);
    check("rst_up_down", int'(up_down), 0);
    check("rst_enable", int'(enable), 0);
    check("rst_clk_ena", int'(clk_ena), 0);
    check("rst_clr_ovf", int'(clr_overflow), 0);
    check("rst_clr_unf", int'(clr_underflow), 0);
    check("rst_pslverr", int'(pslverr), 0);
    check("rst_prdata", int'(prdata), 0);
    check("pready", int'(pready), 1);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    rst_n = 1'b1;
    #2;
    check("idle_prdata", int'(prdata), 0);
    @(posedge clk); #1;

    // Register table
    for (int i = 0; i < 17; i++) begin
      overflow  = vecs[i].ovf;
      underflow = vecs[i].unf;
      if (vecs[i].wr) begin
        apb_write(vecs[i].addr, vecs[i].data, vecs[i].err);
      end else begin
        exp_q.push_back(vecs[i].data);
        apb_read(vecs[i].addr, vecs[i].err);
      end
    end
    overflow = 1'b0; underflow = 1'b0;

    // Load and prescale at cks = 0
    apb_write(ADDR_TDR_DEF, 8'd10, 1'b0);
    check("tdr_start_counter", int'(start_counter), 10);
    apb_write(ADDR_TCR_DEF, 8'hB0, 1'b0);
    check("b0_up_down", int'(up_down), 1);
    check("b0_enable", int'(enable), 1);
    watch(20, loads, ticks, clro, clru, first, min_gap, max_gap);
    check("b0_load_pulses", loads, 1);
    check("b0_ticks", ticks, 10);
    check("b0_min_gap", min_gap, 2);
    check("b0_max_gap", max_gap, 2);

    // Rate change to cks = 3 while running
    apb_write(ADDR_TCR_DEF, 8'h33, 1'b0);
    watch(40, loads, ticks, clro, clru, first, min_gap, max_gap);
    check("cks3_first_le16", int'(first >= 1 && first <= 16), 1);
    check("cks3_min_gap", min_gap, 16);
    check("cks3_max_gap", max_gap, 16);
    check("cks3_enough_ticks", int'(ticks >= 2), 1);
    check("cks3_no_load", loads, 0);

    // Direction change after a tick, back to cks = 0
    wait_tick(40);
    apb_write(ADDR_TCR_DEF, 8'h10, 1'b0);
    check("dir_up_down", int'(up_down), 0);
    check("dir_enable", int'(enable), 1);
    watch(12, loads, ticks, clro, clru, first, min_gap, max_gap);
    check("dir_no_load", loads, 0);
    check("dir_ticks", ticks, 6);
    check("dir_min_gap", min_gap, 2);

    // Status read and clear pulses
    underflow = 1'b1;
    exp_q.push_back(8'h02);
    apb_read(ADDR_TSR_DEF, 1'b0);
    apb_write(ADDR_TSR_DEF, 8'h03, 1'b0);
    watch(8, loads, ticks, clro, clru, first, min_gap, max_gap);
    check("tsr3_clr_ovf", clro, 1);
    check("tsr3_clr_unf", clru, 1);
    apb_write(ADDR_TSR_DEF, 8'h00, 1'b0);
    watch(8, loads, ticks, clro, clru, first, min_gap, max_gap);
    check("tsr0_clr_ovf", clro, 0);
    check("tsr0_clr_unf", clru, 0);
    apb_write(ADDR_TSR_DEF, 8'h01, 1'b0);
    watch(8, loads, ticks, clro, clru, first, min_gap, max_gap);
    check("tsr1_clr_ovf", clro, 1);
    check("tsr1_clr_unf", clru, 0);
    underflow = 1'b0;

    // Bad address write/read leaves state alone
    apb_write(8'h07, 8'hFF, 1'b1);
    check("bad_start_counter", int'(start_counter), 10);
    check("bad_up_down", int'(up_down), 0);
    check("bad_enable", int'(enable), 1);
    watch(6, loads, ticks, clro, clru, first, min_gap, max_gap);
    check("bad_no_load", loads, 0);
    check("bad_no_clr", clro + clru, 0);
    exp_q.push_back(8'h10);
    apb_read(ADDR_TCR_DEF, 1'b0);
    exp_q.push_back(8'h00);
    apb_read(8'h07, 1'b1);

    // Disable stops ticks
    apb_write(ADDR_TCR_DEF, 8'h00, 1'b0);
    watch(20, loads, ticks, clro, clru, first, min_gap, max_gap);
    check("dis_ticks", ticks, 0);

    // Reset asserted during a TDR write access phase
    apb_write(ADDR_TDR_DEF, 8'h55, 1'b0);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = ADDR_TDR_DEF; pwdata = 8'h77;
    @(posedge clk); #1;
    penable = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_pslverr", int'(pslverr), 0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    rst_n = 1'b1;
    exp_q.push_back(8'h00);
    apb_read(ADDR_TDR_DEF, 1'b0);

    // Reset cancels a pending load pulse
    apb_write(ADDR_TCR_DEF, 8'h80, 1'b0);
    check("ld_pulse_high", int'(load), 1);
    rst_n = 1'b0;
    #1;
    check("ld_pulse_cancel", int'(load), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // No tick after reset until enable is written
    watch(40, loads, ticks, clro, clru, first, min_gap, max_gap);
    check("postrst_ticks", ticks, 0);
    check("postrst_loads", loads, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
